// File: rtl/case_3_pkg.sv
// Shared constants and types for the case_3 product pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package case_3_pkg;

    localparam int DIN_WIDTH = 13;
    localparam int ACC_WIDTH = 20;

    // Clamp rails for the signed accumulator.
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_e;

endpackage

// File: rtl/case_3_sat_add.sv
// Sign-extends a product, adds it to an accumulator and clamps to the accumulator range.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module case_3_sat_add
    import case_3_pkg::*;
(
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    input  logic signed [DIN_WIDTH-1:0] din,
    output logic signed [ACC_WIDTH-1:0] sum_out,
    output logic                        ovf
);

    logic signed [ACC_WIDTH:0] wide;

    // One extra bit holds the exact sum; disagreement of the top two bits means it left the range.
    always_comb begin
        wide = {acc_in[ACC_WIDTH-1], acc_in}
             + {{(ACC_WIDTH+1-DIN_WIDTH){din[DIN_WIDTH-1]}}, din};
        ovf  = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
        if (!ovf) begin
            sum_out = wide[ACC_WIDTH-1:0];
        end else if (wide[ACC_WIDTH]) begin
            sum_out = SAT_MIN;
        end else begin
            sum_out = SAT_MAX;
        end
    end

endmodule

// File: rtl/case_3_prod_accum_13s_20s.sv
// Accumulates a frame of signed products into a saturating sum, one result per frame.
// Latency: result valid the cycle after the closing product is accepted.
// Backpressure: input stalls (in_ready=0) while a result waits for out_ready; one bubble per frame.
module case_3_prod_accum_13s_20s
    import case_3_pkg::*;
#(
    parameter int LEN       = 256,
    parameter int CNT_WIDTH = $clog2(LEN + 1)
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic signed [DIN_WIDTH-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic signed [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]        out_count,
    output logic                        out_sat,
    output logic                        out_valid,
    input  logic                        out_ready
);

    state_e                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
    logic                        sat_q, sat_d;
    logic signed [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0]        out_count_q, out_count_d;
    logic                        out_sat_q, out_sat_d;

    logic signed [ACC_WIDTH-1:0] sum;
    logic                        ovf;
    logic [CNT_WIDTH-1:0]        cnt_inc;
    logic                        frame_end;

    case_3_sat_add u_sat_add (
        .acc_in  (acc_q),
        .din     (in_data),
        .sum_out (sum),
        .ovf     (ovf)
    );

    // Next-state: accumulate in ACC, close the frame on in_last or the LEN-th product, drain in OUT.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        cnt_inc     = cnt_q + 1'b1;
        frame_end   = in_last || (cnt_q == CNT_WIDTH'(LEN - 1));
        unique case (state_q)
            ST_ACC: begin
                if (in_valid) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    sat_d = sat_q | ovf;
                    if (frame_end) begin
                        out_data_d  = sum;
                        out_count_d = cnt_inc;
                        out_sat_d   = sat_q | ovf;
                        state_d     = ST_OUT;
                    end
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                    state_d = ST_ACC;
                end
            end
            default: state_d = ST_ACC;
        endcase
    end

    // State and result registers; reset drops any partial frame.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state_q     <= ST_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = (state_q == ST_OUT);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule
